ballot_controller: RTL and testbench
====================================

BALLOT_CONTROLLER -- requirements
Module: ballot_controller

Interface
REQ-001 Parameter HOLD_CYCLES, default 50_000_000: consecutive cycles a single button must be held to register a vote; legal range 2..2^32-1.
REQ-002 Parameter CONF_CYCLES, default 25_000_000: cycles the confirm LED stays lit; legal range 1..2^32-1.
REQ-003 Parameter TIMEOUT_CYCLES, default 500_000_000: armed-ballot expiry; used only with BALLOT_TIMEOUT_EN.
REQ-004 clk  in  1  system clock; all logic on its rising edge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 enable_ballot  in  1  presiding-officer request to arm one ballot.
REQ-007 btn  in  3  candidate buttons, bit0=BJP, bit1=CONG, bit2=NOTA; already synchronised.
REQ-008 vote_pulse  out  3  one-cycle, one-hot increment strobe to the tally counters.
REQ-009 conf  out  3  one-hot confirm LED for the committed candidate.
REQ-010 ready  out  1  high while a ballot is armed and awaiting a vote.
REQ-011 err_multi  out  1  one-cycle flag: more than one button sampled high while armed.
REQ-012 timeout  out  1  one-cycle flag: armed ballot expired.
REQ-013 ballot_count  out  10  total ballots committed since reset.

Function
REQ-014 The FSM SHALL have states IDLE, ARMED, HOLD, COMMIT, CONFIRM and RELEASE; all outputs SHALL be registered or decoded from state only.
REQ-015 IDLE: enable_ballot=1 -> ARMED; enable_ballot SHALL be ignored in every other state.
REQ-016 ARMED: ready=1; exactly one btn bit high -> latch candidate, hold_cnt=1, go to HOLD; two or more bits high -> stay in ARMED, err_multi=1 that cycle; btn=0 -> stay.
REQ-017 HOLD: btn equal to the latched one-hot value -> hold_cnt+1; when hold_cnt reaches HOLD_CYCLES-1 with btn still matching -> COMMIT.
REQ-018 HOLD: any btn value other than the latched one-hot (release or extra button) -> ARMED with hold_cnt cleared and no vote.
REQ-019 Latency: for a button first sampled in ARMED at edge e0 and held through edge e(HOLD_CYCLES-1), vote_pulse SHALL be high in exactly the cycle following edge e(HOLD_CYCLES-1).
REQ-020 COMMIT lasts one cycle: vote_pulse[cand]=1, ballot_count increments and saturates at 1023, next state CONFIRM.
REQ-021 CONFIRM: conf[cand]=1 for exactly CONF_CYCLES cycles, then RELEASE.
REQ-022 RELEASE: conf=0; stay until btn=0, then IDLE; each enable_ballot SHALL yield at most one vote.
REQ-023 The latched candidate SHALL NOT change between HOLD and the end of CONFIRM.

Reset
REQ-024 When reset=1 at an edge, the FSM SHALL enter IDLE and clear hold_cnt, conf_cnt and the timeout counter.
REQ-025 Reset values SHALL be vote_pulse=0, conf=0, ready=0, err_multi=0, timeout=0 and ballot_count=0.
REQ-026 Reset SHALL take priority over every input; a reset during HOLD or CONFIRM SHALL discard the ballot with no vote_pulse.

Configuration
REQ-027 With BALLOT_TIMEOUT_EN defined, a counter SHALL start at entry to ARMED and run through ARMED and HOLD; after TIMEOUT_CYCLES cycles without reaching COMMIT, the FSM SHALL go to IDLE and pulse timeout for one cycle.
REQ-028 A commit occurring in the same cycle as expiry SHALL win, and the timeout SHALL be suppressed.
REQ-029 Without BALLOT_TIMEOUT_EN, timeout SHALL be tied to 0, no timeout counter SHALL be built, and ARMED SHALL persist indefinitely.

Verification (HOLD_CYCLES=4, CONF_CYCLES=3, TIMEOUT_CYCLES=20)
REQ-030 enable pulse, then btn=001 held for 4 edges -> vote_pulse=001 for 1 cycle, conf=001 for 3 cycles, ballot_count=1.
REQ-031 btn=001 for 2 cycles, then 000, then 010 held -> no BJP vote; vote_pulse=010 after 4 edges of 010.
REQ-032 btn=011 while armed -> err_multi=1 each such cycle, no vote, ready stays 1.
REQ-033 After a vote, keep btn=100 held and pulse enable_ballot -> still in RELEASE, no second vote; release, then enable -> ready=1.
REQ-034 reset asserted during CONFIRM -> conf=0, ready=0 and ballot_count=0 on the next cycle.
REQ-035 (BALLOT_TIMEOUT_EN) arm with no buttons for 20 cycles -> timeout=1 for one cycle, then ready=0 and no vote.

Source files
------------

// File: rtl/ballot_controller.sv
// ballot_controller: arms one ballot per officer request, registers a vote after a
// button is held HOLD_CYCLES cycles, then lights the confirm LED and waits for release.
// Latency: vote_pulse is high in the cycle after the HOLD_CYCLES-th matching sample.
// No flow control: button inputs are sampled every cycle; enable_ballot is honoured only in IDLE.
// Optional build macro BALLOT_TIMEOUT_EN adds an armed-ballot expiry after TIMEOUT_CYCLES.
// Ports: clk, reset (sync, active-high), enable_ballot, btn[2:0] (BJP/CONG/NOTA),
//        vote_pulse[2:0], conf[2:0], ready, err_multi, timeout, ballot_count[9:0].
module ballot_controller #(
    parameter logic [31:0] HOLD_CYCLES    = 32'd50_000_000,
    parameter logic [31:0] CONF_CYCLES    = 32'd25_000_000,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd500_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable_ballot,
    input  logic [2:0] btn,
    output logic [2:0] vote_pulse,
    output logic [2:0] conf,
    output logic       ready,
    output logic       err_multi,
    output logic       timeout,
    output logic [9:0] ballot_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_HOLD,
        S_COMMIT,
        S_CONFIRM,
        S_RELEASE
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [2:0]  cand;
    logic [31:0] hold_cnt;
    logic [31:0] conf_cnt;
    logic        btn_one_hot;
    logic        btn_multi;
    logic        btn_match;
    logic        hold_done;
    logic        commit_go;
    logic        expire;

    assign btn_one_hot = (btn == 3'b001) || (btn == 3'b010) || (btn == 3'b100);
    assign btn_multi   = (btn[0] & btn[1]) | (btn[0] & btn[2]) | (btn[1] & btn[2]);
    assign btn_match   = (btn == cand);
    assign hold_done   = (hold_cnt >= HOLD_CYCLES - 32'd1);
    // Commit is decided in HOLD only; it takes precedence over a coincident expiry.
    assign commit_go   = (state == S_HOLD) && btn_match && hold_done;

`ifdef BALLOT_TIMEOUT_EN
    // Counts every cycle spent in ARMED or HOLD; HOLD->ARMED fallbacks do not restart it.
    logic [31:0] tmo_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt <= '0;
            timeout <= 1'b0;
        end else begin
            if (state == S_ARMED || state == S_HOLD) begin
                tmo_cnt <= tmo_cnt + 32'd1;
            end else begin
                tmo_cnt <= '0;
            end
            timeout <= expire && !commit_go;
        end
    end

    assign expire = (state == S_ARMED || state == S_HOLD) &&
                    (tmo_cnt >= TIMEOUT_CYCLES - 32'd1);
`else
    // No expiry in this build; the parameter stays in the interface so both builds share it.
    assign expire  = 1'b0;
    assign timeout = 1'b0 & (TIMEOUT_CYCLES != 32'd0);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        ready      = 1'b0;
        vote_pulse = 3'b000;
        conf       = 3'b000;
        case (state)
            S_IDLE: begin
                if (enable_ballot) begin
                    state_nxt = S_ARMED;
                end
            end
            S_ARMED: begin
                ready = 1'b1;
                if (expire) begin
                    state_nxt = S_IDLE;
                end else if (btn_one_hot) begin
                    state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (commit_go) begin
                    state_nxt = S_COMMIT;
                end else if (expire) begin
                    state_nxt = S_IDLE;
                end else if (!btn_match) begin
                    state_nxt = S_ARMED;
                end
            end
            S_COMMIT: begin
                vote_pulse = cand;
                state_nxt  = S_CONFIRM;
            end
            S_CONFIRM: begin
                conf = cand;
                if (conf_cnt >= CONF_CYCLES - 32'd1) begin
                    state_nxt = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (btn == 3'b000) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cand         <= 3'b000;
            hold_cnt     <= '0;
            conf_cnt     <= '0;
            err_multi    <= 1'b0;
            ballot_count <= '0;
        end else begin
            err_multi <= (state == S_ARMED) && btn_multi;

            // Candidate is captured only in ARMED, so it is frozen from HOLD through CONFIRM.
            if (state == S_ARMED && btn_one_hot && !expire) begin
                cand <= btn;
            end

            if (state == S_ARMED && btn_one_hot) begin
                hold_cnt <= 32'd1;
            end else if (state == S_HOLD && btn_match) begin
                hold_cnt <= hold_cnt + 32'd1;
            end else begin
                hold_cnt <= '0;
            end

            if (state == S_CONFIRM) begin
                conf_cnt <= conf_cnt + 32'd1;
            end else begin
                conf_cnt <= '0;
            end

            if (state == S_COMMIT && ballot_count != 10'd1023) begin
                ballot_count <= ballot_count + 10'd1;
            end
        end
    end

endmodule

// File: tb/tb_ballot_controller.sv
// Self-checking bench for ballot_controller with HOLD=4, CONF=3, TIMEOUT=20.
// Directed scenarios plus randomized ballots scored against a segment-level model.
// Timeout scenarios follow the BALLOT_TIMEOUT_EN build macro.
module tb_ballot_controller;

    localparam int H = 4;
    localparam int C = 3;
    localparam int T = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable_ballot = 1'b0;
    logic [2:0] btn = 3'b000;
    logic [2:0] vote_pulse;
    logic [2:0] conf;
    logic       ready;
    logic       err_multi;
    logic       timeout;
    logic [9:0] ballot_count;

    int n_checks = 0;
    int n_errors = 0;
    int exp_count = 0;

    ballot_controller #(
        .HOLD_CYCLES   (32'd4),
        .CONF_CYCLES   (32'd3),
        .TIMEOUT_CYCLES(32'd20)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable_ballot(enable_ballot),
        .btn          (btn),
        .vote_pulse   (vote_pulse),
        .conf         (conf),
        .ready        (ready),
        .err_multi    (err_multi),
        .timeout      (timeout),
        .ballot_count (ballot_count)
    );

    always #5 clk = ~clk;

    // Apply inputs for one clock edge, then settle 1 time unit after the edge.
    task automatic step(input logic en, input logic [2:0] b);
        enable_ballot = en;
        btn = b;
        @(posedge clk);
        #1;
        enable_ballot = 1'b0;
    endtask

    function automatic int sat_inc(input int c);
        return (c >= 1023) ? 1023 : c + 1;
    endfunction

    task automatic test_reset;
        reset = 1'b1;
        step(1'b1, 3'b111);
        step(1'b0, 3'b000);
        n_checks++;
        if ({vote_pulse, conf, ready, err_multi, timeout, ballot_count} !== 19'd0) begin
            n_errors++;
            $display("FAIL reset_outputs got vote=%b conf=%b ready=%b err=%b tmo=%b cnt=%0d want all 0",
                     vote_pulse, conf, ready, err_multi, timeout, ballot_count);
        end
        reset = 1'b0;
        step(1'b0, 3'b000);
        n_checks++;
        if (ready !== 1'b0) begin
            n_errors++;
            $display("FAIL idle_after_reset ready=%b want 0", ready);
        end
        exp_count = 0;
    endtask

    task automatic test_basic_vote;
        int conf_cycles = 0;
        step(1'b1, 3'b000);
        n_checks++;
        if (ready !== 1'b1) begin
            n_errors++;
            $display("FAIL basic_armed ready=%b want 1", ready);
        end
        for (int i = 1; i <= H; i++) begin
            step(1'b0, 3'b001);
            n_checks++;
            if (vote_pulse !== ((i == H) ? 3'b001 : 3'b000)) begin
                n_errors++;
                $display("FAIL basic_vote_step%0d vote=%b want %b", i, vote_pulse,
                         (i == H) ? 3'b001 : 3'b000);
            end
        end
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 3'b000);
            if (conf == 3'b001) conf_cycles++;
            else if (conf !== 3'b000) begin
                n_checks++;
                n_errors++;
                $display("FAIL basic_conf_value conf=%b want 001 or 000", conf);
            end
        end
        exp_count = sat_inc(exp_count);
        n_checks++;
        if (conf_cycles != C || ballot_count !== 10'(exp_count)) begin
            n_errors++;
            $display("FAIL basic_conf_count conf_cycles=%0d cnt=%0d want %0d,%0d",
                     conf_cycles, ballot_count, C, exp_count);
        end
    endtask

    task automatic test_abort_switch;
        logic [2:0] seq [7] = '{3'b001, 3'b001, 3'b000, 3'b010, 3'b010, 3'b010, 3'b010};
        int votes = 0;
        step(1'b1, 3'b000);
        for (int i = 0; i < 7; i++) begin
            step(1'b0, seq[i]);
            if (i < 6 && vote_pulse !== 3'b000) begin
                n_checks++;
                n_errors++;
                $display("FAIL abort_early_vote step=%0d vote=%b want 000", i, vote_pulse);
            end
        end
        n_checks++;
        if (vote_pulse !== 3'b010) begin
            n_errors++;
            $display("FAIL abort_cong_vote vote=%b want 010", vote_pulse);
        end
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 3'b000);
            if (vote_pulse !== 3'b000) votes++;
        end
        exp_count = sat_inc(exp_count);
        n_checks++;
        if (votes != 0 || ballot_count !== 10'(exp_count)) begin
            n_errors++;
            $display("FAIL abort_extra extra_votes=%0d cnt=%0d want 0,%0d", votes, ballot_count, exp_count);
        end
    endtask

    task automatic test_multi_and_release;
        step(1'b1, 3'b000);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 3'b011);
            n_checks++;
            if (err_multi !== 1'b1 || ready !== 1'b1 || vote_pulse !== 3'b000) begin
                n_errors++;
                $display("FAIL multi_press err=%b ready=%b vote=%b want 1,1,000", err_multi, ready, vote_pulse);
            end
        end
        step(1'b0, 3'b000);
        n_checks++;
        if (err_multi !== 1'b0) begin
            n_errors++;
            $display("FAIL multi_clear err=%b want 0", err_multi);
        end
        for (int i = 1; i <= H; i++) step(1'b0, 3'b100);
        n_checks++;
        if (vote_pulse !== 3'b100) begin
            n_errors++;
            $display("FAIL nota_vote vote=%b want 100", vote_pulse);
        end
        exp_count = sat_inc(exp_count);
        for (int j = 1; j <= 8; j++) begin
            step((j == 2 || j == 6), 3'b100);
            n_checks++;
            if (vote_pulse !== 3'b000 || ready !== 1'b0) begin
                n_errors++;
                $display("FAIL release_hold j=%0d vote=%b ready=%b want 000,0", j, vote_pulse, ready);
            end
        end
        step(1'b0, 3'b000);
        n_checks++;
        if (ready !== 1'b0 || ballot_count !== 10'(exp_count)) begin
            n_errors++;
            $display("FAIL release_idle ready=%b cnt=%0d want 0,%0d", ready, ballot_count, exp_count);
        end
        step(1'b1, 3'b000);
        n_checks++;
        if (ready !== 1'b1) begin
            n_errors++;
            $display("FAIL rearm ready=%b want 1", ready);
        end
    endtask

    // Enters armed (left armed by the previous test).
    task automatic test_reset_mid_ballot;
        for (int i = 0; i < H; i++) step(1'b0, 3'b001);
        step(1'b0, 3'b001);
        n_checks++;
        if (conf !== 3'b001) begin
            n_errors++;
            $display("FAIL confirm_before_reset conf=%b want 001", conf);
        end
        reset = 1'b1;
        step(1'b0, 3'b001);
        reset = 1'b0;
        exp_count = 0;
        n_checks++;
        if (conf !== 3'b000 || ready !== 1'b0 || ballot_count !== 10'd0) begin
            n_errors++;
            $display("FAIL reset_in_confirm conf=%b ready=%b cnt=%0d want 000,0,0", conf, ready, ballot_count);
        end
        step(1'b0, 3'b000);
        step(1'b1, 3'b000);
        step(1'b0, 3'b001);
        step(1'b0, 3'b001);
        reset = 1'b1;
        step(1'b0, 3'b001);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 3'b001);
            n_checks++;
            if (vote_pulse !== 3'b000 || ready !== 1'b0) begin
                n_errors++;
                $display("FAIL reset_in_hold i=%0d vote=%b ready=%b want 000,0", i, vote_pulse, ready);
            end
        end
        step(1'b0, 3'b000);
    endtask

    // Model: a ballot is a list of button segments separated by idle gaps. The first
    // one-hot segment at least H long wins; its vote appears on its H-th sample. Every
    // sample of a multi-button segment before that raises err_multi once.
    task automatic test_random;
        logic [2:0] pat_q[$];
        int         len_q[$];
        for (int n = 0; n < 30; n++) begin
            int npre, exp_idx, exp_err, idx, vote_idx, votes, obs_err, conf_cycles;
            logic [2:0] winner, vote_val;
            pat_q.delete();
            len_q.delete();
            npre = $urandom_range(0, 2);
            exp_err = 0;
            idx = 0;
            for (int s = 0; s < npre; s++) begin
                if ($urandom_range(0, 1) == 1) begin
                    logic [2:0] mp [4] = '{3'b011, 3'b101, 3'b110, 3'b111};
                    int l = $urandom_range(1, 3);
                    pat_q.push_back(mp[$urandom_range(0, 3)]);
                    len_q.push_back(l);
                    exp_err += l;
                end else begin
                    pat_q.push_back(3'b001 << $urandom_range(0, 2));
                    len_q.push_back($urandom_range(1, H - 1));
                end
                pat_q.push_back(3'b000);
                len_q.push_back($urandom_range(1, 2));
            end
            foreach (len_q[k]) idx += len_q[k];
            winner = 3'b001 << $urandom_range(0, 2);
            exp_idx = idx + H;
            pat_q.push_back(winner);
            len_q.push_back(H + $urandom_range(0, 3));
            pat_q.push_back(3'b000);
            len_q.push_back(8);

            step(1'b1, 3'b000);
            n_checks++;
            if (ready !== 1'b1) begin
                n_errors++;
                $display("FAIL rand_arm n=%0d ready=%b want 1", n, ready);
            end
            idx = 0; votes = 0; obs_err = 0; conf_cycles = 0; vote_idx = -1; vote_val = 3'b000;
            foreach (pat_q[k]) begin
                for (int c = 0; c < len_q[k]; c++) begin
                    step(1'b0, pat_q[k]);
                    idx++;
                    if (err_multi === 1'b1) obs_err++;
                    if (vote_pulse !== 3'b000) begin
                        votes++;
                        vote_idx = idx;
                        vote_val = vote_pulse;
                    end
                    if (conf !== 3'b000) begin
                        conf_cycles++;
                        n_checks++;
                        if (conf !== winner) begin
                            n_errors++;
                            $display("FAIL rand_conf_val n=%0d conf=%b want %b", n, conf, winner);
                        end
                    end
                end
            end
            exp_count = sat_inc(exp_count);
            n_checks++;
            if (votes != 1 || vote_idx != exp_idx || vote_val !== winner) begin
                n_errors++;
                $display("FAIL rand_vote n=%0d votes=%0d at=%0d val=%b want 1 at %0d val %b",
                         n, votes, vote_idx, vote_val, exp_idx, winner);
            end
            n_checks++;
            if (obs_err != exp_err) begin
                n_errors++;
                $display("FAIL rand_err n=%0d err_cycles=%0d want %0d", n, obs_err, exp_err);
            end
            n_checks++;
            if (conf_cycles != C || ballot_count !== 10'(exp_count) || ready !== 1'b0) begin
                n_errors++;
                $display("FAIL rand_tail n=%0d conf_cycles=%0d cnt=%0d ready=%b want %0d,%0d,0",
                         n, conf_cycles, ballot_count, ready, C, exp_count);
            end
        end
    endtask

`ifdef BALLOT_TIMEOUT_EN
    task automatic test_timeout;
        int votes = 0;
        step(1'b1, 3'b000);
        for (int i = 1; i <= T + 1; i++) begin
            step(1'b0, 3'b000);
            n_checks++;
            if (timeout !== (i == T) || ready !== (i < T) || vote_pulse !== 3'b000) begin
                n_errors++;
                $display("FAIL expiry i=%0d tmo=%b ready=%b vote=%b want %b,%b,000",
                         i, timeout, ready, vote_pulse, (i == T), (i < T));
            end
        end
        // Commit on the expiry edge: the vote wins.
        step(1'b1, 3'b000);
        for (int i = 1; i <= T - H; i++) step(1'b0, 3'b000);
        for (int i = 1; i <= H; i++) step(1'b0, 3'b001);
        n_checks++;
        if (vote_pulse !== 3'b001 || timeout !== 1'b0) begin
            n_errors++;
            $display("FAIL commit_vs_expiry vote=%b tmo=%b want 001,0", vote_pulse, timeout);
        end
        exp_count = sat_inc(exp_count);
        for (int i = 0; i < 6; i++) step(1'b0, 3'b000);
        // One cycle later the ballot expires mid-hold.
        step(1'b1, 3'b000);
        for (int i = 1; i <= T - H + 1; i++) step(1'b0, 3'b000);
        for (int i = 1; i <= H; i++) begin
            step(1'b0, 3'b001);
            if (vote_pulse !== 3'b000) votes++;
            if (i == H - 1) begin
                n_checks++;
                if (timeout !== 1'b1) begin
                    n_errors++;
                    $display("FAIL expiry_in_hold tmo=%b want 1", timeout);
                end
            end
        end
        step(1'b0, 3'b000);
        n_checks++;
        if (votes != 0 || ballot_count !== 10'(exp_count)) begin
            n_errors++;
            $display("FAIL expiry_no_vote votes=%0d cnt=%0d want 0,%0d", votes, ballot_count, exp_count);
        end
    endtask
`else
    task automatic test_timeout;
        int bad = 0;
        step(1'b1, 3'b000);
        for (int i = 0; i < T + 10; i++) begin
            step(1'b0, 3'b000);
            if (ready !== 1'b1 || timeout !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_errors++;
            $display("FAIL armed_persists bad_cycles=%0d want 0", bad);
        end
        for (int i = 0; i < H; i++) step(1'b0, 3'b010);
        n_checks++;
        if (vote_pulse !== 3'b010) begin
            n_errors++;
            $display("FAIL late_vote vote=%b want 010", vote_pulse);
        end
        exp_count = sat_inc(exp_count);
        for (int i = 0; i < 6; i++) step(1'b0, 3'b000);
    endtask
`endif

    task automatic test_saturation;
        int votes = 0;
        reset = 1'b1;
        step(1'b0, 3'b000);
        reset = 1'b0;
        exp_count = 0;
        for (int n = 0; n < 1030; n++) begin
            step(1'b1, 3'b000);
            for (int i = 0; i < H; i++) step(1'b0, 3'b100);
            if (vote_pulse === 3'b100) votes++;
            for (int i = 0; i < 5; i++) step(1'b0, 3'b000);
            exp_count = sat_inc(exp_count);
        end
        n_checks++;
        if (votes != 1030 || ballot_count !== 10'(exp_count) || ballot_count !== 10'd1023) begin
            n_errors++;
            $display("FAIL saturation votes=%0d cnt=%0d want 1030,%0d", votes, ballot_count, exp_count);
        end
    endtask

    initial begin
        test_reset();
        test_basic_vote();
        test_abort_switch();
        test_multi_and_release();
        test_reset_mid_ballot();
        test_random();
        test_timeout();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
